// File: rtl/dmem_arb_pkg.sv
// Shared state encoding and port indices for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way grant: a lone valid wins outright; on a tie the port
// named by prefer wins. Output is one-hot or zero.
module dmem_arb_pick (
  input  logic [1:0] valid,
  input  logic       prefer,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid == 2'b11) begin
      grant[prefer] = 1'b1;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 64-bit data memory (IDLE->ACCESS->RESP).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t             state_q, state_d;
  logic [1:0]         grant;
  logic               prefer;
  logic               hs;
  logic               sel;
  logic               owner_q;
  logic               we_q;
  logic               err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [ADDR_W-1:0]  addr_in;

  dmem_arb_pick u_pick (
    .valid  (req_valid),
    .prefer (prefer),
    .grant  (grant)
  );

  assign hs      = (state_q == S_IDLE) && (|req_valid);
  assign sel     = grant[P_DBG];
  assign addr_in = sel ? req_addr1 : req_addr0;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= P_CPU;
    end else if (hs) begin
      last_q <= sel;
    end
  end

  assign prefer = ~last_q;
`else
  assign prefer = P_CPU;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Range check is taken at handshake; the latched error gates both enables in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= P_CPU;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (hs) begin
      owner_q <= sel;
      we_q    <= req_we[sel];
      err_q   <= (addr_in >= ADDR_W'(DEPTH));
      addr_q  <= addr_in;
      wdata_q <= sel ? req_wdata1 : req_wdata0;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = '0;
    resp_valid   = '0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    mem_address  = '0;
    mem_wdata    = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = rst ? 2'b00 : grant;
        if (|req_valid) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        mem_address  = addr_q;
        mem_wdata    = wdata_q;
        mem_read_en  = !we_q && !err_q;
        mem_write_en = we_q && !err_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        resp_valid[owner_q] = 1'b1;
        resp_err            = err_q;
        if (!we_q && !err_q) resp_rdata = mem_rdata;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a registered-read memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [63:0] req_addr0, req_addr1;
  logic [63:0] req_wdata0, req_wdata1;
  logic [1:0]  resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [63:0] mem_rdata;

  logic [63:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .DEPTH(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr0    (req_addr0),
    .req_addr1    (req_addr1),
    .req_wdata0   (req_wdata0),
    .req_wdata1   (req_wdata1),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[7:0]] <= mem_wdata;
    if (mem_read_en) mem_rdata <= mem[mem_address[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request on port p in IDLE, checks ready, returns at the ACCESS negedge.
  task automatic start(input string tag, input int p, input logic we,
                       input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    req_valid = (p == 1) ? 2'b10 : 2'b01;
    req_we    = {we, we};
    if (p == 1) begin req_addr1 = a; req_wdata1 = d; end
    else        begin req_addr0 = a; req_wdata0 = d; end
    #1;
    chk({tag, "_ready"}, 64'(req_ready), (p == 1) ? 64'd2 : 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
  endtask

  int exp_order [8];
  int rem0, rem1, n, got;

  initial begin
    rst = 1'b1;
    req_valid = 2'b01; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    mem_rdata = '0;
    for (int unsigned i = 0; i < 256; i++) mem[i] = '0;
    #12;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_we", 64'(mem_write_en), 64'd0);
    chk("rst_mem_addr", mem_address, 64'd0);
    req_valid = 2'b00;
    @(negedge clk); rst = 1'b0;

    // Test 1: port0 write addr 5
    start("t1", 0, 1'b1, 64'd5, 64'hDEAD_BEEF);
    chk("t1_mem_we", 64'(mem_write_en), 64'd1);
    chk("t1_mem_re", 64'(mem_read_en), 64'd0);
    chk("t1_mem_addr", mem_address, 64'd5);
    chk("t1_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("t1_ready_access", 64'(req_ready), 64'd0);
    @(negedge clk); #1;
    chk("t1_resp_valid", 64'(resp_valid), 64'd1);
    chk("t1_resp_err", 64'(resp_err), 64'd0);
    chk("t1_resp_rdata", resp_rdata, 64'd0);
    chk("t1_mem_we_resp", 64'(mem_write_en), 64'd0);

    // Test 2: port0 read addr 5
    start("t2", 0, 1'b0, 64'd5, 64'd0);
    chk("t2_mem_re", 64'(mem_read_en), 64'd1);
    chk("t2_mem_we", 64'(mem_write_en), 64'd0);
    @(negedge clk); #1;
    chk("t2_resp_valid", 64'(resp_valid), 64'd1);
    chk("t2_resp_rdata", resp_rdata, 64'hDEAD_BEEF);

    // Test 3: both ports contending, four writes each
`ifdef DMEM_ARB_RR_EN
    exp_order = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    rem0 = 4; rem1 = 4; n = 0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge clk);
      req_valid  = {rem1 > 0, rem0 > 0};
      req_we     = 2'b11;
      req_addr0  = 64'(32 + 4 - rem0);
      req_wdata0 = 64'(100 + 4 - rem0);
      req_addr1  = 64'(48 + 4 - rem1);
      req_wdata1 = 64'(200 + 4 - rem1);
      #1;
      if (req_ready != 2'b00) begin
        got = req_ready[1] ? 1 : 0;
        chk($sformatf("t3_grant%0d", n), 64'(got), 64'(exp_order[n]));
        n++;
        if (got == 1) rem1--; else rem0--;
      end
    end
    chk("t3_count", 64'(n), 64'd8);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    // Test 4: port1 read out of range
    start("t4", 1, 1'b0, 64'd256, 64'd0);
    chk("t4_mem_re", 64'(mem_read_en), 64'd0);
    chk("t4_mem_we", 64'(mem_write_en), 64'd0);
    @(negedge clk); #1;
    chk("t4_resp_valid", 64'(resp_valid), 64'd2);
    chk("t4_resp_err", 64'(resp_err), 64'd1);
    chk("t4_resp_rdata", resp_rdata, 64'd0);

    // Test 5: reset during ACCESS of a write
    start("t5", 0, 1'b1, 64'd7, 64'h1234);
    chk("t5_mem_we_pre", 64'(mem_write_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_mem_we_rst", 64'(mem_write_en), 64'd0);
    chk("t5_mem_addr_rst", mem_address, 64'd0);
    chk("t5_mem_wdata_rst", mem_wdata, 64'd0);
    @(negedge clk); #1;
    chk("t5_resp_valid_rst", 64'(resp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("t5_resp_valid_after", 64'(resp_valid), 64'd0);
    start("t5b", 0, 1'b0, 64'd5, 64'd0);
    chk("t5b_mem_re", 64'(mem_read_en), 64'd1);
    @(negedge clk); #1;
    chk("t5b_resp_valid", 64'(resp_valid), 64'd1);
    chk("t5b_resp_rdata", resp_rdata, 64'hDEAD_BEEF);

    // Test 6: back-to-back port0 reads; ready only every third cycle
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 2'b01; req_we = 2'b00; req_addr0 = 64'd5;
      end
      #1;
      chk($sformatf("t6_ready%0d", i), 64'(req_ready), (i % 3 == 0) ? 64'd1 : 64'd0);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
